// File: rtl/dllp_tx_arbiter_if.sv
// rtl/dllp_tx_arbiter_if.sv - DLLP source streams and merged transmit stream bundle
interface dllp_tx_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int USER_WIDTH = 3,
  parameter int N_SRC      = 3
);
  logic [N_SRC*DATA_WIDTH-1:0] s_axis_tdata;
  logic [N_SRC*KEEP_WIDTH-1:0] s_axis_tkeep;
  logic [N_SRC*USER_WIDTH-1:0] s_axis_tuser;
  logic [N_SRC-1:0]            s_axis_tvalid;
  logic [N_SRC-1:0]            s_axis_tlast;
  logic [N_SRC-1:0]            s_axis_tready;
  logic [DATA_WIDTH-1:0]       m_axis_tdata;
  logic [KEEP_WIDTH-1:0]       m_axis_tkeep;
  logic [USER_WIDTH-1:0]       m_axis_tuser;
  logic                        m_axis_tvalid;
  logic                        m_axis_tlast;
  logic                        m_axis_tready;

  // master: DLLP producers plus framer (drive sources, accept merged stream)
  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );

  // slave: the arbiter that sinks the sources and sources the merged stream
  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );
endinterface

// File: rtl/dllp_tx_arbiter.sv
// rtl/dllp_tx_arbiter.sv - packet-atomic DLLP transmit arbiter with starvation guard
module dllp_tx_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int KEEP_WIDTH   = DATA_WIDTH/8,
  parameter int USER_WIDTH   = 3,
  parameter int N_SRC        = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tx_hold_i,
  dllp_tx_arbiter_if.slave bus,
  output logic [N_SRC-1:0] grant_o,
  output logic [N_SRC-1:0] starved_o
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic [CW-1:0]    wait_q [N_SRC];
  logic [CW-1:0]    wait_d [N_SRC];

  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] pick;
  logic             last_hs;

  logic [DATA_WIDTH-1:0] m_tdata;
  logic [KEEP_WIDTH-1:0] m_tkeep;
  logic [USER_WIDTH-1:0] m_tuser;
  logic                  m_tvalid;
  logic                  m_tlast;
  logic [N_SRC-1:0]      s_tready;

  assign req = bus.s_axis_tvalid;

  // Starved flags come straight from the registered wait counters
  always_comb begin
    starved_o = '0;
    for (int i = 0; i < N_SRC; i++) begin
      starved_o[i] = (wait_q[i] >= LIMIT);
    end
  end

  // Starved requesters take precedence; within a class the lowest index wins
  always_comb begin
    cand = ((req & starved_o) != '0) ? (req & starved_o) : req;
    pick = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
  end

  // Forward the granted source; grant_q is all-zero when idle so outputs read 0
  always_comb begin
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tuser  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q[i]) begin
        m_tdata     = bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        m_tkeep     = bus.s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        m_tuser     = bus.s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        m_tvalid    = bus.s_axis_tvalid[i];
        m_tlast     = bus.s_axis_tlast[i];
        s_tready[i] = bus.m_axis_tready;
      end
    end
  end

  assign last_hs = m_tvalid & bus.m_axis_tready & m_tlast;

  // Grant/release decisions and wait-counter bookkeeping at packet end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (!tx_hold_i && (req != '0)) begin
          grant_d = pick;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (last_hs) begin
          grant_d = '0;
          state_d = ST_IDLE;
          for (int i = 0; i < N_SRC; i++) begin
            if (grant_q[i]) begin
              wait_d[i] = '0;
            end else if (req[i]) begin
              wait_d[i] = (wait_q[i] == LIMIT) ? wait_q[i] : wait_q[i] + CW'(1);
            end else begin
              wait_d[i] = '0;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, grant and counter registers; reset aborts any packet in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      for (int i = 0; i < N_SRC; i++) begin
        wait_q[i] <= wait_d[i];
      end
    end
  end

  assign grant_o           = grant_q;
  assign bus.m_axis_tdata  = m_tdata;
  assign bus.m_axis_tkeep  = m_tkeep;
  assign bus.m_axis_tuser  = m_tuser;
  assign bus.m_axis_tvalid = m_tvalid;
  assign bus.m_axis_tlast  = m_tlast;
  assign bus.s_axis_tready = s_tready;
endmodule

// File: tb/tb_dllp_tx_arbiter.sv
// tb/tb_dllp_tx_arbiter.sv - self-checking bench for the DLLP transmit arbiter
module tb_dllp_tx_arbiter;
  localparam int N   = 3;
  localparam int DW  = 32;
  localparam int KW  = 4;
  localparam int UW  = 3;
  localparam int LIM = 4;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  typedef struct {
    int            cyc;
    int            src;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } obs_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         hold;
  logic [N-1:0] grant;
  logic [N-1:0] starved;

  int tests = 0;
  int fails = 0;

  beat_t srcq [N][$];
  obs_t  log_q[$];
  bit    pres [N];
  bit    rnd_mode;
  int    cyc;

  // packet-level reference: owner of the output, per-source passed-over counts
  bit    m_busy;
  int    m_own;
  int    m_wait [N];

  always #5 clk = ~clk;

  dllp_tx_arbiter_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .N_SRC(N)) bus ();

  dllp_tx_arbiter #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .N_SRC(N), .STARVE_LIMIT(LIM)
  ) dut (
    .clk_i(clk), .rst_i(rst), .tx_hold_i(hold), .bus(bus),
    .grant_o(grant), .starved_o(starved)
  );

  function automatic int onehot_idx(logic [N-1:0] g);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  function automatic void model_edge(logic [N-1:0] v, logic [N-1:0] l, logic mr, logic h, logic r);
    int p;
    if (r) begin
      m_busy = 0;
      m_own  = 0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
      return;
    end
    if (!m_busy) begin
      if (!h && v != '0) begin
        p = -1;
        for (int i = 0; i < N; i++) if (p < 0 && v[i] && m_wait[i] >= LIM) p = i;
        for (int i = 0; i < N; i++) if (p < 0 && v[i]) p = i;
        m_busy = 1;
        m_own  = p;
      end
    end else if (v[m_own] && mr && l[m_own]) begin
      for (int i = 0; i < N; i++) begin
        if (i == m_own) m_wait[i] = 0;
        else if (v[i]) m_wait[i] = (m_wait[i] + 1 > LIM) ? LIM : m_wait[i] + 1;
        else m_wait[i] = 0;
      end
      m_busy = 0;
    end
  endfunction

  task automatic present();
    for (int i = 0; i < N; i++) begin
      if (!pres[i] && srcq[i].size() > 0 && (!rnd_mode || $urandom_range(0, 9) < 7)) pres[i] = 1;
      if (pres[i]) begin
        bus.s_axis_tdata[i*DW +: DW] = srcq[i][0].d;
        bus.s_axis_tkeep[i*KW +: KW] = srcq[i][0].k;
        bus.s_axis_tuser[i*UW +: UW] = srcq[i][0].u;
        bus.s_axis_tlast[i]          = srcq[i][0].l;
        bus.s_axis_tvalid[i]         = 1'b1;
      end else begin
        bus.s_axis_tdata[i*DW +: DW] = $urandom;
        bus.s_axis_tkeep[i*KW +: KW] = '0;
        bus.s_axis_tuser[i*UW +: UW] = '0;
        bus.s_axis_tlast[i]          = 1'($urandom_range(0, 1));
        bus.s_axis_tvalid[i]         = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0] v, l, hs;
    logic mr, h, r;
    #1;
    v  = bus.s_axis_tvalid;
    l  = bus.s_axis_tlast;
    mr = bus.m_axis_tready;
    h  = hold;
    r  = rst;
    hs = bus.s_axis_tready & v;
    if (bus.m_axis_tvalid && mr)
      log_q.push_back('{cyc, onehot_idx(grant), bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast});
    @(posedge clk);
    model_edge(v, l, mr, h, r);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        void'(srcq[i].pop_front());
        pres[i] = 0;
      end
    end
    present();
    #1;
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    srcq[0].push_back('{32'h12345678, 4'hF, 3'd2, 1'b1});
    present();
    rst = 1'b1;
    run(3);
    tests++; if (grant !== 3'b000) begin fails++; $display("FAIL reset_grant: got %b want 000", grant); end
    tests++; if (starved !== 3'b000) begin fails++; $display("FAIL reset_starved: got %b want 000", starved); end
    tests++; if (bus.m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b want 0", bus.m_axis_tvalid); end
    tests++; if (bus.s_axis_tready !== 3'b000) begin fails++; $display("FAIL reset_sready: got %b want 000", bus.s_axis_tready); end
    tests++; if (bus.m_axis_tdata !== 32'h0 || bus.m_axis_tlast !== 1'b0) begin
      fails++; $display("FAIL reset_idle_data: got %h/%b want 0/0", bus.m_axis_tdata, bus.m_axis_tlast);
    end
    rst = 1'b0;
    run(4);
    log_q.delete();
  endtask

  task automatic test_single();
    int c0;
    log_q.delete();
    srcq[1].push_back('{32'hA0000010, 4'hF, 3'd1, 1'b0});
    srcq[1].push_back('{32'h0000BEEF, 4'h3, 3'd1, 1'b1});
    present();
    #1;
    c0 = cyc;
    tests++; if (grant !== 3'b000 || bus.m_axis_tvalid !== 1'b0) begin
      fails++; $display("FAIL single_idle: grant=%b tvalid=%b want 000/0", grant, bus.m_axis_tvalid);
    end
    tick();
    tests++; if (grant !== 3'b010) begin fails++; $display("FAIL single_grant: got %b want 010", grant); end
    run(2);
    tests++; if (grant !== 3'b000) begin fails++; $display("FAIL single_release: got %b want 000", grant); end
    tests++; if (log_q.size() != 2) begin fails++; $display("FAIL single_count: got %0d want 2", log_q.size()); end
    else begin
      tests++; if (log_q[0].cyc - c0 != 1 || log_q[1].cyc - c0 != 2) begin
        fails++; $display("FAIL single_latency: got %0d,%0d want 1,2", log_q[0].cyc - c0, log_q[1].cyc - c0);
      end
      tests++; if (log_q[0].d !== 32'hA0000010 || log_q[0].l !== 1'b0 || log_q[0].src != 1) begin
        fails++; $display("FAIL single_beat0: got %h/%b/src%0d want a0000010/0/src1", log_q[0].d, log_q[0].l, log_q[0].src);
      end
      tests++; if (log_q[1].d !== 32'h0000BEEF || log_q[1].k !== 4'h3 || log_q[1].l !== 1'b1 || log_q[1].src != 1) begin
        fails++; $display("FAIL single_beat1: got %h/%h/%b/src%0d want 0000beef/3/1/src1", log_q[1].d, log_q[1].k, log_q[1].l, log_q[1].src);
      end
    end
  endtask

  task automatic test_contention();
    int c0;
    int es [4] = '{0, 0, 2, 2};
    int ec [4] = '{1, 2, 4, 5};
    logic [DW-1:0] ed [4] = '{32'h11, 32'h12, 32'h21, 32'h22};
    log_q.delete();
    srcq[0].push_back('{32'h11, 4'hF, 3'd0, 1'b0});
    srcq[0].push_back('{32'h12, 4'hF, 3'd0, 1'b1});
    srcq[2].push_back('{32'h21, 4'hF, 3'd0, 1'b0});
    srcq[2].push_back('{32'h22, 4'hF, 3'd0, 1'b1});
    present();
    c0 = cyc;
    run(8);
    tests++; if (log_q.size() != 4) begin fails++; $display("FAIL contention_count: got %0d want 4", log_q.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (log_q[k].src != es[k] || log_q[k].cyc - c0 != ec[k] || log_q[k].d !== ed[k]) begin
          fails++;
          $display("FAIL contention_beat%0d: got src%0d cyc%0d %h want src%0d cyc%0d %h",
                   k, log_q[k].src, log_q[k].cyc - c0, log_q[k].d, es[k], ec[k], ed[k]);
        end
      end
    end
  endtask

  task automatic test_starvation();
    int es [8] = '{0, 0, 0, 0, 2, 0, 0, 2};
    bit c4, c5;
    int n;
    pulse_reset();
    log_q.delete();
    for (int k = 0; k < 6; k++) srcq[0].push_back('{32'h100 + k, 4'hF, 3'd0, 1'b1});
    for (int k = 0; k < 2; k++) srcq[2].push_back('{32'h200 + k, 4'hF, 3'd0, 1'b1});
    present();
    c4 = 0;
    c5 = 0;
    n  = 0;
    while (log_q.size() < 8 && n < 60) begin
      tick();
      n++;
      if (log_q.size() == 4 && !c4) begin
        c4 = 1;
        tests++; if (starved !== 3'b100) begin fails++; $display("FAIL starve_flag: got %b want 100", starved); end
      end
      if (log_q.size() == 5 && !c5) begin
        c5 = 1;
        tests++; if (starved !== 3'b000) begin fails++; $display("FAIL starve_clear: got %b want 000", starved); end
      end
    end
    tests++; if (log_q.size() < 8) begin fails++; $display("FAIL starve_timeout: got %0d packets want 8", log_q.size()); end
    else begin
      for (int k = 0; k < 8; k++) begin
        tests++; if (log_q[k].src != es[k]) begin
          fails++; $display("FAIL starve_order%0d: got src%0d want src%0d", k, log_q[k].src, es[k]);
        end
      end
    end
    run(2);
  endtask

  task automatic test_backpressure();
    log_q.delete();
    srcq[1].push_back('{32'h31, 4'hF, 3'd3, 1'b0});
    srcq[1].push_back('{32'h32, 4'hF, 3'd3, 1'b0});
    srcq[1].push_back('{32'h33, 4'h7, 3'd3, 1'b1});
    present();
    run(3);
    bus.m_axis_tready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== 32'h33 || bus.m_axis_tlast !== 1'b1 ||
          bus.s_axis_tready !== 3'b000 || grant !== 3'b010) begin
        fails++;
        $display("FAIL bp_hold%0d: got v=%b d=%h l=%b rdy=%b g=%b want 1/33/1/000/010",
                 k, bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, bus.s_axis_tready, grant);
      end
      tick();
    end
    bus.m_axis_tready = 1'b1;
    run(4);
    tests++;
    if (log_q.size() != 3) begin fails++; $display("FAIL bp_count: got %0d want 3", log_q.size()); end
    else if (log_q[0].d !== 32'h31 || log_q[1].d !== 32'h32 || log_q[2].d !== 32'h33 || log_q[2].l !== 1'b1) begin
      fails++; $display("FAIL bp_order: got %h %h %h want 31 32 33", log_q[0].d, log_q[1].d, log_q[2].d);
    end
  endtask

  task automatic test_hold();
    log_q.delete();
    srcq[1].push_back('{32'h41, 4'hF, 3'd1, 1'b0});
    srcq[1].push_back('{32'h42, 4'hF, 3'd1, 1'b0});
    srcq[1].push_back('{32'h43, 4'hF, 3'd1, 1'b1});
    present();
    run(2);
    hold = 1'b1;
    srcq[0].push_back('{32'h51, 4'hF, 3'd0, 1'b1});
    present();
    run(2);
    tests++; if (log_q.size() != 3 || grant !== 3'b000) begin
      fails++; $display("FAIL hold_complete: got %0d beats grant=%b want 3/000", log_q.size(), grant);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++; if (grant !== 3'b000 || bus.m_axis_tvalid !== 1'b0) begin
        fails++; $display("FAIL hold_blocked%0d: grant=%b v=%b want 000/0", k, grant, bus.m_axis_tvalid);
      end
    end
    hold = 1'b0;
    #1;
    tick();
    tests++; if (grant !== 3'b001) begin fails++; $display("FAIL hold_release: got %b want 001", grant); end
    run(2);
    tests++; if (log_q.size() != 4 || log_q[log_q.size()-1].d !== 32'h51) begin
      fails++; $display("FAIL hold_src0: got %0d beats want 4 ending 51", log_q.size());
    end
  endtask

  task automatic test_reset_mid();
    log_q.delete();
    srcq[2].push_back('{32'h61, 4'hF, 3'd5, 1'b0});
    srcq[2].push_back('{32'h62, 4'hF, 3'd5, 1'b0});
    srcq[2].push_back('{32'h63, 4'hF, 3'd5, 1'b1});
    present();
    run(2);
    pulse_reset();
    tests++; if (grant !== 3'b000 || bus.m_axis_tvalid !== 1'b0 || bus.s_axis_tready !== 3'b000) begin
      fails++; $display("FAIL rstmid_abort: grant=%b v=%b rdy=%b want 000/0/000", grant, bus.m_axis_tvalid, bus.s_axis_tready);
    end
    tests++; if (starved !== 3'b000) begin fails++; $display("FAIL rstmid_starved: got %b want 000", starved); end
    srcq[2].delete();
    pres[2] = 0;
    srcq[2].push_back('{32'h71, 4'hF, 3'd5, 1'b1});
    present();
    log_q.delete();
    #1;
    tick();
    tests++; if (grant !== 3'b100) begin fails++; $display("FAIL rstmid_regrant: got %b want 100", grant); end
    run(2);
    tests++; if (log_q.size() != 1 || log_q[0].d !== 32'h71 || log_q[0].src != 2) begin
      fails++; $display("FAIL rstmid_packet: got %0d beats want 1 beat 71 from src2", log_q.size());
    end
  endtask

  task automatic test_random();
    logic [N-1:0] eg, es, er;
    logic ev, el;
    logic [DW-1:0] ed;
    logic [KW-1:0] ek;
    int n, len;
    pulse_reset();
    rnd_mode = 1;
    for (int c = 0; c < 700; c++) begin
      for (int i = 0; i < N; i++) begin
        if (srcq[i].size() < 4 && $urandom_range(0, 3) == 0) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++)
            srcq[i].push_back('{$urandom, 4'($urandom), 3'(i), 1'(b == len - 1)});
        end
      end
      hold = ($urandom_range(0, 9) == 0);
      bus.m_axis_tready = ($urandom_range(0, 9) < 8);
      #1;
      eg = '0; er = '0; ev = 1'b0; el = 1'b0; ed = '0; ek = '0;
      if (m_busy) begin
        eg[m_own] = 1'b1;
        er[m_own] = bus.m_axis_tready;
        ev = bus.s_axis_tvalid[m_own];
        el = bus.s_axis_tlast[m_own];
        ed = bus.s_axis_tdata[m_own*DW +: DW];
        ek = bus.s_axis_tkeep[m_own*KW +: KW];
      end
      for (int i = 0; i < N; i++) es[i] = (m_wait[i] >= LIM);
      tests++; if (grant !== eg) begin fails++; $display("FAIL rnd_grant@%0d: got %b want %b", c, grant, eg); end
      tests++; if (starved !== es) begin fails++; $display("FAIL rnd_starved@%0d: got %b want %b", c, starved, es); end
      tests++; if (bus.s_axis_tready !== er) begin fails++; $display("FAIL rnd_sready@%0d: got %b want %b", c, bus.s_axis_tready, er); end
      tests++;
      if (bus.m_axis_tvalid !== ev || bus.m_axis_tlast !== el || bus.m_axis_tdata !== ed || bus.m_axis_tkeep !== ek) begin
        fails++;
        $display("FAIL rnd_out@%0d: got v%b l%b %h k%h want v%b l%b %h k%h", c,
                 bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata, bus.m_axis_tkeep, ev, el, ed, ek);
      end
      tick();
    end
    rnd_mode = 0;
    hold = 1'b0;
    bus.m_axis_tready = 1'b1;
    n = 0;
    while ((srcq[0].size() + srcq[1].size() + srcq[2].size() != 0 || grant != '0) && n < 200) begin
      tick();
      n++;
    end
    tests++; if (n >= 200) begin fails++; $display("FAIL rnd_drain: queues not empty after %0d cycles", n); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    hold = 1'b0;
    rnd_mode = 0;
    cyc = 0;
    m_busy = 0;
    m_own = 0;
    for (int i = 0; i < N; i++) begin
      m_wait[i] = 0;
      pres[i] = 0;
    end
    bus.m_axis_tready = 1'b1;
    present();
    run(2);
    rst = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_starvation();
    test_backpressure();
    test_hold();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
